// File: rtl/nes_video_pkg.sv
// Shared video-block types and sizes.
// Palette geometry and palette-loader FSM states.
package nes_video_pkg;

  localparam int PAL_ENTRIES = 64;
  localparam int PAL_IDX_W   = 6;
  localparam int PAL_RGB_W   = 24;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PEND,
    FULL
  } pal_state_t;

endpackage

// File: rtl/nes_palette_loader.sv
// Palette-RAM writer fed by the HPS .pal download stream.
// Assembles R,G,B bytes into entries, optionally deferring writes to blanking.
module nes_palette_loader
  import nes_video_pkg::*;
#(
  parameter bit WRITE_IN_BLANK = 1'b1,
  parameter int NUM_ENTRIES    = PAL_ENTRIES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dl_active,
  input  logic                 dl_wr,
  input  logic [7:0]           dl_data,
  input  logic                 blank,
  output logic                 dl_wait,
  output logic                 load_color,
  output logic [PAL_IDX_W-1:0] load_color_index,
  output logic [PAL_RGB_W-1:0] load_color_data,
  output logic                 busy,
  output logic                 palette_valid,
  output logic [6:0]           entries_written,
  output logic                 dl_err
);

  localparam logic [PAL_IDX_W-1:0] LAST_IDX =
    PAL_IDX_W'(NUM_ENTRIES - 1);
  localparam logic [6:0] NUM_W = 7'(NUM_ENTRIES);

  pal_state_t state, state_n;

  logic                 act_q;
  logic                 rise;
  logic                 fall;
  logic                 byte_ok;
  logic                 fire;
  logic                 last;
  logic [1:0]           phase;
  logic [PAL_IDX_W-1:0] idx;
  logic [7:0]           r_q;
  logic [7:0]           g_q;

  assign rise    = dl_active & ~act_q;
  assign fall    = ~dl_active & act_q;
  assign byte_ok = dl_wr & dl_active;
  assign last    = (idx == LAST_IDX);

  // A restart in the same cycle as a pending write wins.
  assign fire = (state == PEND) &&
                (!WRITE_IN_BLANK || blank) && !rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (rise) begin
      state_n = COLLECT;
    end else begin
      unique case (state)
        IDLE: state_n = IDLE;
        COLLECT: begin
          if (fall) begin
            state_n = IDLE;
          end else if (byte_ok && phase == 2'd2) begin
            state_n = PEND;
          end
        end
        PEND: begin
          if (fire) begin
            if (!dl_active) begin
              state_n = IDLE;
            end else if (last) begin
              state_n = FULL;
            end else begin
              state_n = COLLECT;
            end
          end
        end
        FULL: begin
          if (fall) begin
            state_n = IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    load_color = fire;
    dl_wait    = (state == PEND) && !fire;
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_q            <= 1'b0;
      phase            <= 2'd0;
      idx              <= '0;
      r_q              <= '0;
      g_q              <= '0;
      load_color_index <= '0;
      load_color_data  <= '0;
      entries_written  <= '0;
      palette_valid    <= 1'b0;
      dl_err           <= 1'b0;
    end else begin
      act_q <= dl_active;
      if (rise) begin
        phase           <= 2'd0;
        idx             <= '0;
        entries_written <= '0;
        palette_valid   <= 1'b0;
        dl_err          <= 1'b0;
      end else begin
        unique case (state)
          COLLECT: begin
            if (fall) begin
              phase <= 2'd0;
              if (entries_written < NUM_W) begin
                dl_err <= 1'b1;
              end
            end else if (byte_ok) begin
              unique case (1'b1)
                phase == 2'd0: begin
                  r_q   <= dl_data;
                  phase <= 2'd1;
                end
                phase == 2'd1: begin
                  g_q   <= dl_data;
                  phase <= 2'd2;
                end
                default: begin
                  load_color_data  <= {r_q, g_q, dl_data};
                  load_color_index <= idx;
                  phase            <= 2'd0;
                end
              endcase
            end
          end
          PEND: begin
            if (fire) begin
              entries_written <= entries_written + 7'd1;
              idx             <= idx + 1'b1;
              if (last) begin
                palette_valid <= 1'b1;
              end else if (!dl_active) begin
                dl_err <= 1'b1;
              end else if (byte_ok) begin
                // dl_wait is low on the strobe cycle, so take the next R.
                r_q   <= dl_data;
                phase <= 2'd1;
              end
            end else if (byte_ok) begin
              dl_err <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nes_palette_loader.sv
// Scoreboard bench for the palette loader.
// u0: immediate writes; u1: blank-gated writes.
module tb_nes_palette_loader;

  typedef struct {
    logic [5:0]  idx;
    logic [23:0] data;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] act = '0;
  logic [1:0] wr = '0;
  logic [7:0] dat [2];
  logic       blank0 = 1'b0;
  logic       blank1 = 1'b0;

  logic        wt0, lc0, busy0, val0, err0;
  logic [5:0]  idx0;
  logic [23:0] data0;
  logic [6:0]  cnt0;
  logic        wt1, lc1, busy1, val1, err1;
  logic [5:0]  idx1;
  logic [23:0] data1;
  logic [6:0]  cnt1;

  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   loads1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nes_palette_loader #(.WRITE_IN_BLANK(1'b0), .NUM_ENTRIES(64)) u0 (
    .clk(clk), .reset(reset), .dl_active(act[0]), .dl_wr(wr[0]),
    .dl_data(dat[0]), .blank(blank0), .dl_wait(wt0),
    .load_color(lc0), .load_color_index(idx0),
    .load_color_data(data0), .busy(busy0), .palette_valid(val0),
    .entries_written(cnt0), .dl_err(err0)
  );

  nes_palette_loader #(.WRITE_IN_BLANK(1'b1), .NUM_ENTRIES(64)) u1 (
    .clk(clk), .reset(reset), .dl_active(act[1]), .dl_wr(wr[1]),
    .dl_data(dat[1]), .blank(blank1), .dl_wait(wt1),
    .load_color(lc1), .load_color_index(idx1),
    .load_color_data(data1), .busy(busy1), .palette_valid(val1),
    .entries_written(cnt1), .dl_err(err1)
  );

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (!reset && lc0) begin
      if (q0.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL u0_unexpected_load got_idx=%0d want=none", idx0);
      end else begin
        e = q0.pop_front();
        chk("u0_idx", 32'(idx0), 32'(e.idx));
        chk("u0_data", 32'(data0), 32'(e.data));
        if (e.cyc >= 0) chk("u0_latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!reset && lc1) begin
      loads1++;
      chk("u1_wait_low_on_load", 32'(wt1), 32'd0);
      if (q1.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL u1_unexpected_load got_idx=%0d want=none", idx1);
      end else begin
        e = q1.pop_front();
        chk("u1_idx", 32'(idx1), 32'(e.idx));
        chk("u1_data", 32'(data1), 32'(e.data));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input int sel, input logic [7:0] b,
                      input bit pb, input logic [5:0] pi,
                      input logic [23:0] pd);
    exp_t e;
    int n = 0;
    while ((sel == 1 ? wt1 : wt0) && n < 500) begin
      tick(1);
      n++;
    end
    if (n >= 500) begin
      checks++;
      fails++;
      $display("FAIL dl_wait_timeout got=stuck want=release");
    end
    wr[sel] = 1'b1;
    dat[sel] = b;
    if (pb) begin
      e.idx = pi;
      e.data = pd;
      e.cyc = (sel == 0) ? cyc + 1 : -1;
      if (sel == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    tick(1);
    wr[sel] = 1'b0;
  endtask

  // Entry k of the pattern file is {k, k+1, k+2}.
  task automatic stream(input int sel, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      int e = i / 3;
      int c = i % 3;
      send(sel, 8'(e + c), (c == 2) && (e < 64), 6'(e),
           {8'(e), 8'(e + 1), 8'(e + 2)});
    end
  endtask

  task automatic restart(input int sel);
    act[sel] = 1'b0;
    tick(1);
    act[sel] = 1'b1;
    tick(1);
  endtask

  initial begin
    int l1;
    int hi;
    dat[0] = '0;
    dat[1] = '0;
    tick(3);
    chk("rst_u0_outs", {lc0, wt0, busy0, val0, err0, cnt0}, '0);
    chk("rst_u0_idx_data", {idx0, data0}, '0);
    chk("rst_u1_outs", {lc1, wt1, busy1, val1, err1, cnt1}, '0);
    reset = 1'b0;
    tick(1);

    restart(0);
    stream(0, 192);
    tick(3);
    chk("full_cnt", 32'(cnt0), 32'd64);
    chk("full_valid", 32'(val0), 32'd1);
    chk("full_err", 32'(err0), 32'd0);
    chk("full_data63", 32'(data0), 32'h3F4041);

    restart(0);
    chk("restart_clear", {val0, cnt0}, '0);
    stream(0, 200);
    tick(3);
    chk("over_cnt", 32'(cnt0), 32'd64);
    chk("over_valid", 32'(val0), 32'd1);
    chk("over_err", 32'(err0), 32'd0);
    chk("over_q_empty", 32'(q0.size()), 32'd0);

    blank1 = 1'b0;
    act[1] = 1'b1;
    tick(1);
    send(1, 8'hFF, 1'b0, 6'd0, 24'h0);
    send(1, 8'h80, 1'b0, 6'd0, 24'h0);
    send(1, 8'h00, 1'b1, 6'd0, 24'hFF8000);
    l1 = loads1;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      if (wt1) hi++;
      tick(1);
    end
    chk("blank_wait_held", hi, 100);
    chk("blank_no_load", loads1, l1);
    wr[1] = 1'b1;
    dat[1] = 8'h55;
    tick(1);
    wr[1] = 1'b0;
    chk("wait_strobe_err", 32'(err1), 32'd1);
    chk("wait_strobe_cnt", 32'(cnt1), 32'd0);
    blank1 = 1'b1;
    tick(2);
    chk("blank_one_load", loads1, l1 + 1);
    send(1, 8'h11, 1'b0, 6'd0, 24'h0);
    send(1, 8'h22, 1'b0, 6'd0, 24'h0);
    send(1, 8'h33, 1'b1, 6'd1, 24'h112233);
    tick(3);
    chk("after_err_cnt", 32'(cnt1), 32'd2);
    chk("after_err_sticky", 32'(err1), 32'd1);

    restart(0);
    stream(0, 100);
    act[0] = 1'b0;
    tick(4);
    chk("short_cnt", 32'(cnt0), 32'd33);
    chk("short_err", 32'(err0), 32'd1);
    chk("short_valid", 32'(val0), 32'd0);
    chk("short_busy", 32'(busy0), 32'd0);
    act[0] = 1'b1;
    tick(2);
    chk("short_restart", {err0, cnt0, busy0}, 9'b1);
    act[0] = 1'b0;
    tick(2);

    blank1 = 1'b0;
    send(1, 8'h01, 1'b0, 6'd0, 24'h0);
    send(1, 8'h02, 1'b0, 6'd0, 24'h0);
    send(1, 8'h03, 1'b0, 6'd0, 24'h0);
    tick(1);
    chk("pend_before_rst", 32'(wt1), 32'd1);
    l1 = loads1;
    reset = 1'b1;
    act[1] = 1'b0;
    blank1 = 1'b1;
    tick(1);
    chk("rst_pend_outs", {lc1, wt1, busy1, val1, err1, cnt1}, '0);
    chk("rst_pend_idx_data", {idx1, data1}, '0);
    reset = 1'b0;
    tick(10);
    chk("rst_pend_no_load", loads1, l1);
    chk("q_empty", 32'(q0.size() + q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/nes_palette_loader.md
Name: nes_palette_loader

Overview:
- Writer side of the video block's palette-RAM load port (load_color / load_color_index / load_color_data).
- Consumes a sequential byte stream from the HPS download channel: a standard .pal file of 64 entries x 3 bytes (R, G, B).
- Emits one 24-bit write per assembled entry, optionally deferred to blanking so the visible picture never shows a torn palette.
- Reports completion, progress and protocol errors to the top level.

Parameters:
- WRITE_IN_BLANK, 1, when 1 a pending write is issued only while blank=1; when 0 it is issued immediately.
- NUM_ENTRIES, 64, number of palette entries accepted per download; the index width stays 6 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- dl_active  in  1  palette download in progress (level)
- dl_wr  in  1  one-cycle byte strobe, valid only while dl_active=1
- dl_data  in  8  download byte
- blank  in  1  HBlank|VBlank from the video block
- dl_wait  out  1  back-pressure to the download channel; the source must not strobe while high
- load_color  out  1  one-cycle palette write strobe
- load_color_index  out  6  entry index
- load_color_data  out  24  {R,G,B} in 'hRRGGBB order
- busy  out  1  download open or a write is pending
- palette_valid  out  1  all NUM_ENTRIES entries written since the last download start
- entries_written  out  7  count of completed writes, 0..64
- dl_err  out  1  sticky: a byte was strobed while dl_wait=1, or the download ended short

Behaviour:
- Reset: all outputs 0, state IDLE, byte phase 0, index 0. Reset mid-operation discards any partial or pending entry.
- States:
  - IDLE: no download open.
  - COLLECT: assembling the bytes of an entry.
  - PEND: entry complete, awaiting write.
  - FULL: NUM_ENTRIES entries written, download still open.
- Download start (rising edge of dl_active, registered edge detect):
  - Any state goes to COLLECT.
  - Phase, index, entries_written, palette_valid and dl_err are cleared.
  - A pending entry is discarded.
- COLLECT, byte assembly on each dl_wr:
  - Phase 0 latches R, phase 1 latches G, phase 2 latches B.
  - Phase wraps 2 to 0.
  - On the phase-2 byte the state goes to PEND.
- PEND:
  - dl_wait=1, registered; it rises the cycle after the B strobe.
  - load_color asserts for exactly one cycle when WRITE_IN_BLANK=0 or blank=1. With WRITE_IN_BLANK=0 this is the cycle after the B strobe.
  - load_color_index and load_color_data are stable during the strobe and held afterwards.
  - dl_wait deasserts in the cycle load_color is high.
  - On the strobe cycle, entries_written increments.
  - Next state is COLLECT if index < NUM_ENTRIES-1; otherwise FULL with palette_valid=1 on the following cycle.
  - Index increments after each write.
- FULL: further dl_wr bytes are ignored, with no error. This lets longer .pal variants (emphasis tables) load their first 64 entries.
- dl_wr during PEND: the byte is dropped and dl_err is set; the state is unchanged.
- dl_wr while dl_active=0: ignored.
- Download end (falling edge of dl_active):
  - From COLLECT, partial bytes are discarded and the state goes to IDLE.
  - From PEND, the pending write still completes (blank-gated), then the state goes to IDLE.
  - If entries_written < NUM_ENTRIES at the end, dl_err=1 and palette_valid stays 0. Entries already written remain in RAM.
- Simultaneous events:
  - A rising edge of dl_active in the same cycle as a pending strobe: the restart wins and the strobe is suppressed.
  - blank falling in the cycle load_color would assert: the write waits for the next blank.
- busy = (state != IDLE).
- load_color is never asserted outside PEND.

Decomposition:
- Shared package nes_video_pkg:
  - PAL_ENTRIES=64.
  - PAL_IDX_W=6.
  - PAL_RGB_W=24.
  - State enum typedef {IDLE, COLLECT, PEND, FULL}.
- No sub-module. The edge detector and byte assembler are inline; the block is a single FSM with a datapath.

Test Plan:
- WRITE_IN_BLANK=0, blank=0; stream 192 bytes where entry k = {k, k+1, k+2}, honouring dl_wait.
  - Expect 64 load_color pulses, each one cycle after its B strobe.
  - Entry 63 has data 'h3F4041.
  - entries_written reaches 64, then palette_valid=1; dl_err=0.
- WRITE_IN_BLANK=1, blank held 0 for 100 cycles after the first entry 'hFF8000.
  - dl_wait is held high and there is no load_color.
  - blank=1 gives one pulse with index 0, data 'hFF8000; dl_wait falls in the same cycle.
- Strobe a byte while dl_wait=1: dl_err=1, the byte is dropped, and the next entry still assembles from the following 3 bytes.
- Stream 200 bytes: exactly 64 writes, the last 8 bytes are ignored, dl_err=0, palette_valid=1.
- Drop dl_active after 100 bytes (33 entries + 1 byte): 33 writes, the partial byte is discarded, dl_err=1, palette_valid=0. A restart then clears dl_err and entries_written to 0.
- Assert reset with an entry pending: no load_color afterwards, and all outputs are 0 the cycle after reset.
